// File: rtl/vx_tag_tracker.sv
// vx_tag_tracker: issues upstream requests downstream with a tag taken
// from an external index buffer, and rejoins each tagged response with
// the metadata stored under that tag.
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   req_*                 upstream request (valid/ready, data, metadata)
//   mem_req_*             tagged request to memory (registered, 1-cycle latency)
//   mem_rsp_*             tagged response from memory
//   rsp_*                 response rejoined with its metadata (registered)
//   ib_*                  external index buffer: acquire/write, release/read, full
//   drain_req/drain_done  quiesce handshake; drain_done is high only in IDLE
//   pending_count         number of live tags
//   tag_err               sticky: a response arrived for a tag that was not live
module vx_tag_tracker #(
    parameter int DATAW     = 32,
    parameter int METAW     = 8,
    parameter int RSP_DATAW = 32,
    parameter int SIZE      = 8,
    parameter int ADDRW     = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [DATAW-1:0]     req_data,
    input  logic [METAW-1:0]     req_meta,

    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [DATAW-1:0]     mem_req_data,
    output logic [ADDRW-1:0]     mem_req_tag,

    input  logic                 mem_rsp_valid,
    output logic                 mem_rsp_ready,
    input  logic [RSP_DATAW-1:0] mem_rsp_data,
    input  logic [ADDRW-1:0]     mem_rsp_tag,

    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [RSP_DATAW-1:0] rsp_data,
    output logic [METAW-1:0]     rsp_meta,

    input  logic [ADDRW-1:0]     ib_write_addr,
    output logic [METAW-1:0]     ib_write_data,
    output logic                 ib_acquire_en,
    output logic [ADDRW-1:0]     ib_read_addr,
    input  logic [METAW-1:0]     ib_read_data,
    output logic                 ib_release_en,
    input  logic                 ib_full,

    input  logic                 drain_req,
    output logic                 drain_done,
    output logic [ADDRW:0]       pending_count,
    output logic                 tag_err
);

    typedef enum logic [1:0] {RUN, DRAIN, IDLE} state_t;

    state_t          state, state_nx;
    logic [SIZE-1:0] live, live_nx;
    logic            do_acq, do_rel, rsp_fire, tag_live;
    logic            rtag_ok, wtag_ok;

    // Tags outside the bitmap (non power-of-two SIZE) are never live.
    assign rtag_ok  = ({1'b0, mem_rsp_tag}   < (ADDRW+1)'(SIZE));
    assign wtag_ok  = ({1'b0, ib_write_addr} < (ADDRW+1)'(SIZE));
    assign tag_live = rtag_ok && live[mem_rsp_tag];

    // A new request may enter only when the output register is free or
    // emptying this cycle, so mem_req_* never change under a stall.
    assign req_ready     = (state == RUN) && !ib_full && (!mem_req_valid || mem_req_ready);
    assign mem_rsp_ready = !rsp_valid || rsp_ready;

    // Enables are gated with reset so the index buffer sees no activity
    // while the block is held in reset.
    assign do_acq   = reset && req_valid && req_ready;
    assign rsp_fire = reset && mem_rsp_valid && mem_rsp_ready;
    assign do_rel   = rsp_fire && tag_live;

    assign ib_acquire_en = do_acq;
    assign ib_release_en = do_rel;
    assign ib_write_data = req_meta;
    assign ib_read_addr  = mem_rsp_tag;
    assign drain_done    = (state == IDLE);

    // Release is applied before acquire; both land in the same cycle.
    always_comb begin
        live_nx = live;
        if (do_rel) live_nx[mem_rsp_tag] = 1'b0;
        if (do_acq && wtag_ok) live_nx[ib_write_addr] = 1'b1;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            RUN:     if (drain_req) state_nx = DRAIN;
            DRAIN:   if (pending_count == '0 && !mem_req_valid && !rsp_valid) state_nx = IDLE;
            IDLE:    if (!drain_req) state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= RUN;
            mem_req_valid <= 1'b0;
            rsp_valid     <= 1'b0;
            live          <= '0;
            pending_count <= '0;
            tag_err       <= 1'b0;
        end else begin
            state <= state_nx;
            live  <= live_nx;

            if (do_acq)             mem_req_valid <= 1'b1;
            else if (mem_req_ready) mem_req_valid <= 1'b0;

            if (do_rel)         rsp_valid <= 1'b1;
            else if (rsp_ready) rsp_valid <= 1'b0;

            if (do_acq && !do_rel)      pending_count <= pending_count + (ADDRW+1)'(1);
            else if (do_rel && !do_acq) pending_count <= pending_count - (ADDRW+1)'(1);

            if (rsp_fire && !tag_live) tag_err <= 1'b1;
        end
    end

    // Payload registers need no reset: they are qualified by the valids.
    always_ff @(posedge clk) begin
        if (do_acq) begin
            mem_req_data <= req_data;
            mem_req_tag  <= ib_write_addr;
        end
        if (do_rel) begin
            rsp_data <= mem_rsp_data;
            rsp_meta <= ib_read_data;
        end
    end

endmodule

// File: tb/tb_vx_tag_tracker.sv
module tb_vx_tag_tracker;
    localparam int SIZE = 8;
    localparam int S_RUN = 0, S_DRAIN = 1, S_IDLE = 2;

    logic        clk, reset;
    logic        req_valid, req_ready;
    logic [31:0] req_data;
    logic [7:0]  req_meta;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_data;
    logic [2:0]  mem_req_tag;
    logic        mem_rsp_valid, mem_rsp_ready;
    logic [31:0] mem_rsp_data;
    logic [2:0]  mem_rsp_tag;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic [7:0]  rsp_meta;
    logic [2:0]  ib_write_addr;
    logic [7:0]  ib_write_data;
    logic        ib_acquire_en;
    logic [2:0]  ib_read_addr;
    logic [7:0]  ib_read_data;
    logic        ib_release_en;
    logic        ib_full;
    logic        drain_req, drain_done;
    logic [3:0]  pending_count;
    logic        tag_err;

    vx_tag_tracker dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_meta(req_meta),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
        .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_meta(rsp_meta),
        .ib_write_addr(ib_write_addr), .ib_write_data(ib_write_data), .ib_acquire_en(ib_acquire_en),
        .ib_read_addr(ib_read_addr), .ib_read_data(ib_read_data), .ib_release_en(ib_release_en),
        .ib_full(ib_full),
        .drain_req(drain_req), .drain_done(drain_done),
        .pending_count(pending_count), .tag_err(tag_err)
    );

    always #5 clk = ~clk;

    // External index buffer: metadata store plus a free-tag list.
    logic [7:0] meta_mem [SIZE];
    logic [2:0] free_q[$];
    bit         force_full;
    assign ib_read_data = meta_mem[ib_read_addr];

    // Reference model: set of live tags, one slot per output register.
    bit          live [SIZE];
    int          m_state;
    bit          m_mrv, m_rv, m_err;
    logic [2:0]  m_mtag;
    logic [31:0] m_mdata, m_rdata;
    logic [7:0]  m_rmeta;

    int n_chk = 0, n_pass = 0;
    bit s_rrdy, s_acq, s_rel;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic int npend();
        int n = 0;
        for (int i = 0; i < SIZE; i++) n += live[i];
        return n;
    endfunction

    task automatic upd_ports();
        ib_full       = force_full || (free_q.size() == 0);
        ib_write_addr = (free_q.size() != 0) ? free_q[0] : 3'd0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < SIZE; i++) begin live[i] = 0; meta_mem[i] = 8'h00; end
        m_state = S_RUN; m_mrv = 0; m_rv = 0; m_err = 0;
        free_q = '{3'd3, 3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};
        force_full = 0;
        upd_ports();
    endtask

    task automatic apply_reset();
        reset = 0;
        req_valid = 1; mem_rsp_valid = 1; mem_rsp_tag = 3'd0;
        mem_req_ready = 1; rsp_ready = 1; drain_req = 0;
        model_reset();
        #1;
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_pending", pending_count, 0);
        chk("rst_tag_err", tag_err, 0);
        chk("rst_drain_done", drain_done, 0);
        chk("rst_acq_en", ib_acquire_en, 0);
        chk("rst_rel_en", ib_release_en, 0);
        @(negedge clk); @(negedge clk);
        reset = 1; req_valid = 0; mem_rsp_valid = 0;
    endtask

    // One clock: drive at negedge, check combinational outputs, advance the
    // model at the edge, check registered outputs at the next negedge.
    task automatic cycle(input bit rv, input logic [31:0] rd, input logic [7:0] rm,
                         input bit mrr, input bit msv, input logic [31:0] msd,
                         input logic [2:0] mst, input bit rr, input bit dr);
        bit e_rr, acq, e_mr, fire, rel;
        int nstate;
        logic [2:0] wtag;
        logic [7:0] rmeta;
        req_valid = rv; req_data = rd; req_meta = rm; mem_req_ready = mrr;
        mem_rsp_valid = msv; mem_rsp_data = msd; mem_rsp_tag = mst;
        rsp_ready = rr; drain_req = dr;
        upd_ports();
        #1;
        e_rr = (m_state == S_RUN) && !ib_full && (!m_mrv || mrr);
        acq  = rv && e_rr;
        e_mr = !m_rv || rr;
        fire = msv && e_mr;
        rel  = fire && live[mst];
        s_rrdy = req_ready; s_acq = ib_acquire_en; s_rel = ib_release_en;
        chk("req_ready", req_ready, e_rr);
        chk("mem_rsp_ready", mem_rsp_ready, e_mr);
        chk("acq_en", ib_acquire_en, acq);
        chk("rel_en", ib_release_en, rel);
        chk("ib_read_addr", ib_read_addr, mst);
        if (acq) chk("ib_write_data", ib_write_data, rm);
        nstate = m_state;
        case (m_state)
            S_RUN:   if (dr) nstate = S_DRAIN;
            S_DRAIN: if (npend() == 0 && !m_mrv && !m_rv) nstate = S_IDLE;
            default: if (!dr) nstate = S_RUN;
        endcase
        wtag = ib_write_addr; rmeta = meta_mem[mst];
        @(posedge clk); #1;
        if (rel) begin live[mst] = 0; free_q.push_back(mst); end
        if (acq) begin live[wtag] = 1; meta_mem[wtag] = rm; void'(free_q.pop_front()); end
        if (fire && !rel) m_err = 1;
        if (acq) begin m_mrv = 1; m_mtag = wtag; m_mdata = rd; end
        else if (mrr) m_mrv = 0;
        if (rel) begin m_rv = 1; m_rdata = msd; m_rmeta = rmeta; end
        else if (rr) m_rv = 0;
        m_state = nstate;
        upd_ports();
        @(negedge clk);
        chk("mem_req_valid", mem_req_valid, m_mrv);
        if (m_mrv) begin
            chk("mem_req_tag", mem_req_tag, m_mtag);
            chk("mem_req_data", mem_req_data, m_mdata);
        end
        chk("rsp_valid", rsp_valid, m_rv);
        if (m_rv) begin
            chk("rsp_data", rsp_data, m_rdata);
            chk("rsp_meta", rsp_meta, m_rmeta);
        end
        chk("pending_count", pending_count, npend());
        chk("tag_err", tag_err, m_err);
        chk("drain_done", drain_done, m_state == S_IDLE);
    endtask

    task automatic idle(input bit dr);
        cycle(0, 0, 0, 1, 0, 0, 0, 1, dr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int live_idx[$];
        bit dr;
        clk = 0; reset = 0;
        req_data = 0; req_meta = 0; mem_rsp_data = 0;
        apply_reset();

        // Response for a tag that is not live: consumed, dropped, sticky error.
        cycle(0, 0, 0, 1, 1, 32'hDEAD, 3'd5, 1, 0);
        chk("p34_err", tag_err, 1);
        chk("p34_rv", rsp_valid, 0);
        idle(0);
        chk("p34_err_hold", tag_err, 1);

        // Single request / response round trip.
        cycle(1, 32'h1111, 8'h5A, 1, 0, 0, 0, 1, 0);
        chk("p32_mrv", mem_req_valid, 1);
        chk("p32_tag", mem_req_tag, 3);
        chk("p32_pc", pending_count, 1);
        cycle(0, 0, 0, 1, 1, 32'hABCD, 3'd3, 1, 0);
        chk("p32_rv", rsp_valid, 1);
        chk("p32_meta", rsp_meta, 8'h5A);
        chk("p32_pc0", pending_count, 0);
        idle(0);

        // Fill all tags, then a release while the buffer is still full.
        for (int i = 0; i < SIZE; i++) cycle(1, $urandom, 8'($urandom), 1, 0, 0, 0, 1, 0);
        chk("p33_pc8", pending_count, 8);
        cycle(1, 32'h5, 8'h5, 1, 1, 32'h77, 3'd0, 1, 0);
        chk("p33_rdy", s_rrdy, 0);
        chk("p33_rel", s_rel, 1);
        chk("p33_noacq", s_acq, 0);
        chk("p33_pc7", pending_count, 7);

        // Acquire and release of different tags in one cycle.
        cycle(1, 32'h22, 8'h22, 1, 1, 32'h88, 3'd2, 1, 0);
        chk("p35_acq", s_acq, 1);
        chk("p35_rel", s_rel, 1);
        chk("p35_pc", pending_count, 7);

        // Drain with two outstanding tags.
        apply_reset();
        cycle(1, 32'hA0, 8'hA0, 1, 0, 0, 0, 1, 0);
        cycle(1, 32'hA1, 8'hA1, 1, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 0, 0, 0, 1, 1);
        cycle(1, 32'hA2, 8'hA2, 1, 0, 0, 0, 1, 1);
        chk("p36_rdy0", s_rrdy, 0);
        cycle(0, 0, 0, 1, 1, 32'hB0, 3'd3, 1, 1);
        cycle(0, 0, 0, 1, 1, 32'hB1, 3'd0, 1, 1);
        for (int i = 0; i < 10 && !drain_done; i++) idle(1);
        chk("p36_done", drain_done, 1);
        idle(0);
        cycle(1, 32'hA3, 8'hA3, 1, 0, 0, 0, 1, 0);
        chk("p36_rdy1", s_rrdy, 1);

        // Stall on mem_req, then reset in the middle of it.
        apply_reset();
        cycle(1, 32'hCAFE, 8'h11, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, $urandom, 8'($urandom), 0, 0, 0, 0, 1, 0);
            chk("p37_rdy", s_rrdy, 0);
            chk("p37_tag", mem_req_tag, 3);
            chk("p37_data", mem_req_data, 32'hCAFE);
        end
        apply_reset();

        // Randomized traffic against the model.
        dr = 0;
        for (int i = 0; i < 1500; i++) begin
            logic [2:0] t;
            if (i == 700) begin apply_reset(); dr = 0; end
            if ($urandom_range(0, 99) < 4) dr = !dr;
            force_full = ($urandom_range(0, 9) == 0);
            live_idx.delete();
            for (int k = 0; k < SIZE; k++) if (live[k]) live_idx.push_back(k);
            if (live_idx.size() != 0 && $urandom_range(0, 9) < 8)
                t = 3'(live_idx[$urandom_range(0, live_idx.size() - 1)]);
            else
                t = 3'($urandom_range(0, SIZE - 1));
            cycle($urandom_range(0, 1), $urandom, 8'($urandom), $urandom_range(0, 9) < 7,
                  $urandom_range(0, 1), $urandom, t, $urandom_range(0, 9) < 7, dr);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/vx_tag_tracker.md
VX_TAG_TRACKER -- requirements
Module: VX_tag_tracker

Interface
REQ-001 SHALL have parameter DATAW, default 32: request payload width.
REQ-002 SHALL have parameter METAW, default 8: per-request metadata width, stored in the external index buffer.
REQ-003 SHALL have parameter RSP_DATAW, default 32: response payload width.
REQ-004 SHALL have parameter SIZE, default 8: number of tags, equal to the index-buffer depth.
REQ-005 SHALL have parameter ADDRW, default LOG2UP(SIZE): tag width.
REQ-006 SHALL have one clock; reset is asynchronous and active-low. Ports: clk in 1, clock; reset in 1, asynchronous active-low reset.
REQ-007 SHALL have ports req_valid in 1, req_ready out 1, req_data in DATAW, req_meta in METAW: upstream request.
REQ-008 SHALL have ports mem_req_valid out 1, mem_req_ready in 1, mem_req_data out DATAW, mem_req_tag out ADDRW: tagged request.
REQ-009 SHALL have ports mem_rsp_valid in 1, mem_rsp_ready out 1, mem_rsp_data in RSP_DATAW, mem_rsp_tag in ADDRW: tagged response.
REQ-010 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_data out RSP_DATAW, rsp_meta out METAW: response rejoined with its metadata.
REQ-011 SHALL have index-buffer ports:
  - ib_write_addr in ADDRW
  - ib_write_data out METAW
  - ib_acquire_en out 1
  - ib_read_addr out ADDRW
  - ib_read_data in METAW (combinational read)
  - ib_release_en out 1
  - ib_full in 1
REQ-012 SHALL have ports drain_req in 1, drain_done out 1, pending_count out ADDRW+1, tag_err out 1.

Function
REQ-013 Request accept SHALL be req_valid && req_ready, where req_ready = (state==RUN) && !ib_full && (!mem_req_valid || mem_req_ready).
REQ-014 On request accept, the block SHALL:
  - assert ib_acquire_en for that cycle with ib_write_data=req_meta;
  - register req_data and ib_write_addr into mem_req_data/mem_req_tag;
  - set mem_req_valid on the next edge (latency 1 cycle).
REQ-015 mem_req_valid SHALL clear after a mem_req_ready handshake unless a new request is accepted in the same cycle.
REQ-016 mem_req_* outputs SHALL hold stable while mem_req_valid && !mem_req_ready.
REQ-017 mem_rsp_ready SHALL equal !rsp_valid || rsp_ready.
REQ-018 ib_read_addr SHALL equal mem_rsp_tag combinationally.
REQ-019 On a response handshake with the tag marked live, the block SHALL:
  - assert ib_release_en;
  - register mem_rsp_data and ib_read_data into rsp_data/rsp_meta;
  - set rsp_valid on the next edge (latency 1 cycle).
REQ-020 The block SHALL keep a SIZE-bit live bitmap: set bit on acquire, clear bit on release.
REQ-021 A response handshake with a non-live tag SHALL be consumed and dropped: no release, no rsp_valid. It SHALL set sticky tag_err, which is cleared only by reset.
REQ-022 pending_count SHALL be +1 on acquire only, -1 on release only, and unchanged on both or neither.
REQ-023 Simultaneous acquire and release, including of different tags, SHALL both take effect in the same cycle.
REQ-024 The FSM SHALL have states RUN, DRAIN, IDLE:
  - RUN -> DRAIN when drain_req=1.
  - DRAIN -> IDLE when pending_count==0 && !mem_req_valid && !rsp_valid.
  - IDLE -> RUN when drain_req=0.
REQ-025 In DRAIN and IDLE, req_ready SHALL be 0, and the response path SHALL continue to operate.
REQ-026 drain_done SHALL be 1 exactly when state==IDLE (registered).
REQ-027 When ib_full=1, req_ready SHALL be 0 and no acquire SHALL occur. ib_full=1 concurrent with a release SHALL still block the acquire that cycle.

Reset
REQ-028 While reset=0, the block SHALL hold: mem_req_valid=0, rsp_valid=0, pending_count=0, bitmap=0, tag_err=0, state=RUN, drain_done=0.
REQ-029 ib_acquire_en and ib_release_en SHALL be 0 while reset=0.
REQ-030 Reset asserted mid-transaction SHALL discard all in-flight state with no output glitch-handshake afterwards.
REQ-031 Data registers are not required to reset.

Verification
REQ-032 Single request req_meta=0x5A with ib_write_addr=3 -> next cycle mem_req_valid=1, mem_req_tag=3, pending_count=1. Then response tag 3 -> next cycle rsp_valid=1, rsp_meta=0x5A, pending_count=0.
REQ-033 SIZE=8, 8 requests with no responses and ib_full asserted after the 8th -> req_ready=0, pending_count=8. One response -> ib_release_en=1, pending_count=7.
REQ-034 Response tag 5 while bitmap bit 5=0 -> mem_rsp_ready honoured, rsp_valid stays 0, tag_err=1 persists.
REQ-035 Request accept and response for tag 2 in the same cycle, pending_count=4 -> both enables high, pending_count stays 4.
REQ-036 drain_req=1 with 2 outstanding -> req_ready=0 immediately. After both responses drain with rsp_ready=1 -> drain_done=1. Then drain_req=0 -> RUN, req_ready=1.
REQ-037 mem_req_ready=0 for 3 cycles with mem_req_valid=1 -> outputs stable, req_ready=0. Assert reset=0 mid-stall -> all valids 0, pending_count=0.
